// File: rtl/useq_pkg.sv
// Shared definitions for the microsequencer: next-address operation codes
// and the default fetch/reset microaddresses.
package useq_pkg;

  typedef enum logic [2:0] {
    N_ENC   = 3'b000,
    N_FETCH = 3'b001,
    N_JMP   = 3'b010,
    N_INC   = 3'b011,
    N_CJMP  = 3'b100,
    N_CWAIT = 3'b101,
    N_CALL  = 3'b110,
    N_RET   = 3'b111
  } nop_e;

  localparam int FETCH_ADDR_DEFAULT = 1;
  localparam int RESET_ADDR_DEFAULT = 0;

endpackage

// File: rtl/useq_stack.sv
// Return-address LIFO for the microsequencer. Pushes are ignored when full
// and pops are ignored when empty; top is valid only when not empty.
module useq_stack #(
  parameter int AW    = 6,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [AW-1:0] push_data_i,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW-1:0] top_o
);

  localparam int PW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0] mem_q [DEPTH];
  logic [PW-1:0] sp_q, sp_d;
  logic [IW-1:0] wr_idx, rd_idx;

  assign empty_o = (sp_q == '0);
  assign full_o  = (sp_q == PW'(DEPTH));
  assign wr_idx  = IW'(sp_q);
  assign rd_idx  = IW'(sp_q - PW'(1));
  assign top_o   = mem_q[rd_idx];

  always_comb begin
    sp_d = sp_q;
    if (push_i && !full_o)      sp_d = sp_q + PW'(1);
    else if (pop_i && !empty_o) sp_d = sp_q - PW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) sp_q <= '0;
    else       sp_q <= sp_d;
  end

  // NOTE: entries are not reset; the pointer alone defines validity, so the
  // storage can map onto plain flops or a register file without a reset port.
  always_ff @(posedge clk) begin
    if (push_i && !full_o) mem_q[wr_idx] <= push_data_i;
  end

endmodule

// File: rtl/microsequencer.sv
// Microprogram sequencer: selects the next microaddress from the current
// microinstruction's N/S/Inv/CR fields, with a call/return stack.
module microsequencer
  import useq_pkg::*;
#(
  parameter  int AW         = 6,
  parameter  int NCOND      = 4,
  parameter  int DEPTH      = 4,
  parameter  int FETCH_ADDR = FETCH_ADDR_DEFAULT,
  parameter  int RESET_ADDR = RESET_ADDR_DEFAULT,
  localparam int SW         = (NCOND > 1) ? $clog2(NCOND) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hold,
  input  logic [2:0]       N,
  input  logic [SW-1:0]    S,
  input  logic             Inv,
  input  logic [AW-1:0]    CR,
  input  logic [AW-1:0]    EncoderOut,
  input  logic [NCOND-1:0] cond,
  output logic [AW-1:0]    state,
  output logic             ovf,
  output logic             unf
);

  nop_e          op;
  logic          c;
  logic [AW-1:0] inc;
  logic [AW-1:0] state_q, state_d;
  logic          ovf_q, ovf_d, unf_q, unf_d;
  logic          push, pop, full, empty;
  logic [AW-1:0] top;

  assign op    = nop_e'(N);
  // Out-of-range selects fall back to cond[0] so a bad S never yields X.
  assign c     = ((int'(S) < NCOND) ? cond[S] : cond[0]) ^ Inv;
  assign inc   = state_q + AW'(1);
  assign state = state_q;
  assign ovf   = ovf_q;
  assign unf   = unf_q;

  useq_stack #(.AW(AW), .DEPTH(DEPTH)) u_stack (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .pop_i       (pop),
    .push_data_i (inc),
    .full_o      (full),
    .empty_o     (empty),
    .top_o       (top)
  );

  // NOTE: non-blocking assignments here so every register samples the
  // pre-edge values of the others, independent of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= AW'(RESET_ADDR);
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // NOTE: state_d gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    if (!hold) begin
      unique case (op)
        N_ENC:   state_d = EncoderOut;
        N_FETCH: state_d = AW'(FETCH_ADDR);
        N_JMP:   state_d = CR;
        N_INC:   state_d = inc;
        N_CJMP:  state_d = c ? CR : inc;
        N_CWAIT: state_d = c ? inc : CR;
        N_CALL:  state_d = CR;
        N_RET:   state_d = empty ? AW'(FETCH_ADDR) : top;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    push  = !hold && (op == N_CALL) && !full;
    pop   = !hold && (op == N_RET) && !empty;
    ovf_d = ovf_q | (!hold && (op == N_CALL) && full);
    unf_d = unf_q | (!hold && (op == N_RET) && empty);
  end

endmodule

// File: tb/tb_microsequencer.sv
// Directed-vector bench for microsequencer with default parameters
// (AW=6, NCOND=4, DEPTH=4, FETCH_ADDR=1, RESET_ADDR=0).
module tb_microsequencer;
  import useq_pkg::*;

  logic       clk = 1'b0;
  logic       reset, hold, Inv;
  logic [2:0] N;
  logic [1:0] S;
  logic [5:0] CR, EncoderOut;
  logic [3:0] cond;
  logic [5:0] state;
  logic       ovf, unf;

  int n_cmp = 0;
  int n_err = 0;

  microsequencer dut (
    .clk        (clk),
    .reset      (reset),
    .hold       (hold),
    .N          (N),
    .S          (S),
    .Inv        (Inv),
    .CR         (CR),
    .EncoderOut (EncoderOut),
    .cond       (cond),
    .state      (state),
    .ovf        (ovf),
    .unf        (unf)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; hold = 1'b0; N = N_INC; S = '0; Inv = 1'b0;
    CR = '0; EncoderOut = '0; cond = '0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (state !== 6'd0) begin n_err++; $display("FAIL reset_state got %0d want 0", state); end
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b want 0", ovf); end
    n_cmp++; if (unf !== 1'b0) begin n_err++; $display("FAIL reset_unf got %b want 0", unf); end
  endtask

  task automatic test_inc();
    N = N_INC;
    for (int i = 1; i <= 3; i++) begin
      step();
      n_cmp++; if (state !== 6'(i)) begin n_err++; $display("FAIL inc_%0d got %0d want %0d", i, state, i); end
    end
  endtask

  task automatic test_cwait();
    N = N_JMP; CR = 6'd2;
    step();
    n_cmp++; if (state !== 6'd2) begin n_err++; $display("FAIL cwait_setup got %0d want 2", state); end
    N = N_CWAIT; S = 2'd0; Inv = 1'b0; CR = 6'd2; cond = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++; if (state !== 6'd2) begin n_err++; $display("FAIL cwait_loop_%0d got %0d want 2", i, state); end
    end
    cond = 4'b0001;
    step();
    n_cmp++; if (state !== 6'd3) begin n_err++; $display("FAIL cwait_exit got %0d want 3", state); end
  endtask

  task automatic test_cjmp();
    N = N_CJMP; S = 2'd2; Inv = 1'b1; CR = 6'h1E; cond = 4'b1011;
    step();
    n_cmp++; if (state !== 6'h1E) begin n_err++; $display("FAIL cjmp_taken got %0h want 1e", state); end
    cond = 4'b0100;
    step();
    n_cmp++; if (state !== 6'h1F) begin n_err++; $display("FAIL cjmp_fall got %0h want 1f", state); end
    S = 2'd1; Inv = 1'b0; CR = 6'd7; cond = 4'b0010;
    step();
    n_cmp++; if (state !== 6'd7) begin n_err++; $display("FAIL cjmp_s1 got %0d want 7", state); end
    cond = 4'b1101;
    step();
    n_cmp++; if (state !== 6'd8) begin n_err++; $display("FAIL cjmp_s1_fall got %0d want 8", state); end
  endtask

  task automatic test_enc_fetch();
    N = N_ENC; EncoderOut = 6'h2A;
    step();
    n_cmp++; if (state !== 6'h2A) begin n_err++; $display("FAIL enc got %0h want 2a", state); end
    N = N_FETCH;
    step();
    n_cmp++; if (state !== 6'd1) begin n_err++; $display("FAIL fetch got %0d want 1", state); end
  endtask

  task automatic test_call_ret();
    logic [5:0] tgt [5];
    logic [5:0] ret [4];
    tgt = '{6'd8, 6'd12, 6'd16, 6'd20, 6'd48};
    ret = '{6'd17, 6'd13, 6'd9, 6'd5};
    do_reset();
    N = N_JMP; CR = 6'd4;
    step();
    N = N_CALL;
    for (int i = 0; i < 5; i++) begin
      CR = tgt[i];
      step();
      n_cmp++; if (state !== tgt[i]) begin n_err++; $display("FAIL call_%0d_state got %0d want %0d", i, state, tgt[i]); end
      n_cmp++; if (ovf !== (i == 4)) begin n_err++; $display("FAIL call_%0d_ovf got %b want %b", i, ovf, (i == 4)); end
    end
    N = N_RET; CR = 6'd0;
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++; if (state !== ret[i]) begin n_err++; $display("FAIL ret_%0d_state got %0d want %0d", i, state, ret[i]); end
      n_cmp++; if (unf !== 1'b0) begin n_err++; $display("FAIL ret_%0d_unf got %b want 0", i, unf); end
    end
    step();
    n_cmp++; if (state !== 6'd1) begin n_err++; $display("FAIL ret_empty_state got %0d want 1", state); end
    n_cmp++; if (unf !== 1'b1) begin n_err++; $display("FAIL ret_empty_unf got %b want 1", unf); end
    n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got %b want 1", ovf); end
  endtask

  task automatic test_wrap_hold();
    do_reset();
    N = N_JMP; CR = 6'd63;
    step();
    N = N_INC;
    step();
    n_cmp++; if (state !== 6'd0) begin n_err++; $display("FAIL wrap got %0d want 0", state); end
    hold = 1'b1; N = N_JMP; CR = 6'd9;
    step();
    step();
    n_cmp++; if (state !== 6'd0) begin n_err++; $display("FAIL hold_jmp got %0d want 0", state); end
    N = N_RET;
    step();
    n_cmp++; if (state !== 6'd0 || unf !== 1'b0) begin n_err++; $display("FAIL hold_ret state %0d unf %b want 0 0", state, unf); end
    hold = 1'b0;
    step();
    n_cmp++; if (state !== 6'd1 || unf !== 1'b1) begin n_err++; $display("FAIL unhold_ret state %0d unf %b want 1 1", state, unf); end
  endtask

  task automatic test_reset_priority();
    do_reset();
    N = N_CALL; CR = 6'd10;
    for (int i = 0; i < 5; i++) step();
    n_cmp++; if (state !== 6'd10 || ovf !== 1'b1) begin n_err++; $display("FAIL rp_setup state %0d ovf %b want 10 1", state, ovf); end
    reset = 1'b1; hold = 1'b1; N = N_CALL; CR = 6'd33;
    step();
    reset = 1'b0; hold = 1'b0;
    n_cmp++; if (state !== 6'd0) begin n_err++; $display("FAIL rp_state got %0d want 0", state); end
    n_cmp++; if (ovf !== 1'b0 || unf !== 1'b0) begin n_err++; $display("FAIL rp_flags ovf %b unf %b want 0 0", ovf, unf); end
    N = N_RET;
    step();
    n_cmp++; if (state !== 6'd1 || unf !== 1'b1) begin n_err++; $display("FAIL rp_stack_empty state %0d unf %b want 1 1", state, unf); end
  endtask

  initial begin
    test_reset();
    test_inc();
    test_cwait();
    test_cjmp();
    test_enc_fetch();
    test_call_ret();
    test_wrap_hold();
    test_reset_priority();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
